// File: rtl/gfx_pkg.sv
// Shared definitions for the graphics address path: colour-depth encoding,
// per-depth bits-per-pixel and pixels-per-strip helpers, and the run FSM states.
// Pure definitions; no timing or flow-control behaviour of its own.
package gfx_pkg;

    typedef enum logic [1:0] {
        BPP8  = 2'd0,
        BPP16 = 2'd1,
        BPP24 = 2'd2,
        BPP32 = 2'd3
    } color_depth_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP1 = 2'd1,
        ST_SETUP2 = 2'd2,
        ST_EMIT   = 2'd3
    } run_state_e;

    // Bits per pixel for a colour depth.
    function automatic logic [5:0] bpp_f(input logic [1:0] d);
        case (d)
            BPP8:    return 6'd8;
            BPP16:   return 6'd16;
            BPP24:   return 6'd24;
            default: return 6'd32;
        endcase
    endfunction

    // Whole pixels that fit in one strip of sw bits; leftover top bits stay unused.
    function automatic logic [15:0] pps_f(input logic [1:0] d, input int sw);
        case (d)
            BPP8:    return 16'(sw / 8);
            BPP16:   return 16'(sw / 16);
            BPP24:   return 16'(sw / 24);
            default: return 16'(sw / 32);
        endcase
    endfunction

endpackage

// File: rtl/gfx_strip_div.sv
// Exact pixel -> (strip, offset-in-strip) divider by the per-depth PPS.
// Latency 2 cycles, fully pipelined: a new operand may enter every cycle.
// No backpressure: free-running pipeline, the caller times its operands.
//
// Ports: clk/rst_n; x_i pixel index and depth_i colour depth (operands);
//        strip_o = x / PPS, k_o = x mod PPS (results, two cycles later).
module gfx_strip_div
    import gfx_pkg::*;
#(
    parameter int SW = 256,
    parameter int KW = $clog2(SW) - 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   x_i,
    input  logic [1:0]    depth_i,
    output logic [15:0]   strip_o,
    output logic [KW-1:0] k_o
);

    // 8/16/32 bpp give power-of-two PPS (shift); 24 bpp needs a true constant divide.
    localparam int          S8  = $clog2(SW / 8);
    localparam int          S16 = $clog2(SW / 16);
    localparam int          S32 = $clog2(SW / 32);
    localparam logic [15:0] P24 = 16'(SW / 24);

    logic [15:0]   q_d;
    logic [15:0]   q1_q;
    logic [KW-1:0] xl1_q;
    logic [KW-1:0] pl1_q;
    logic [15:0]   strip_q;
    logic [KW-1:0] k_q;

    always_comb begin
        q_d = '0;
        case (depth_i)
            BPP8:    q_d = x_i >> S8;
            BPP16:   q_d = x_i >> S16;
            BPP24:   q_d = x_i / P24;
            default: q_d = x_i >> S32;
        endcase
    end

    // The remainder is below 2^KW, so it can be formed from the low KW bits
    // of x, q and PPS only (arithmetic modulo 2^KW).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_q    <= '0;
            xl1_q   <= '0;
            pl1_q   <= '0;
            strip_q <= '0;
            k_q     <= '0;
        end else begin
            q1_q    <= q_d;
            xl1_q   <= x_i[KW-1:0];
            pl1_q   <= KW'(pps_f(depth_i, SW));
            strip_q <= q1_q;
            k_q     <= xl1_q - q1_q[KW-1:0] * pl1_q;
        end
    end

    assign strip_o = strip_q;
    assign k_o     = k_q;

endmodule

// File: rtl/gfx_addr_run_gen.sv
// Turns a horizontal pixel run into one strip-address response per touched strip.
// Latency: first response 3 cycles after request acceptance, then 1 per cycle.
// Backpressure: req_ready_o only in IDLE; rsp_* held stable while rsp_ready_i=0.
//
// Ports: clk/rst_n; base_address_i, color_depth_i, bmp_width_i, bmp_height_i
//        (bitmap config, sampled at acceptance); req_* (run request: x, y, len,
//        tag); rsp_* (strip address, first/last bit mb/me, first/last/clip, tag).
module gfx_addr_run_gen
    import gfx_pkg::*;
#(
    parameter int SW = 256,
    parameter int AW = 32,
    parameter int TW = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AW-1:0]         base_address_i,
    input  logic [1:0]            color_depth_i,
    input  logic [15:0]           bmp_width_i,
    input  logic [15:0]           bmp_height_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [15:0]           req_x_i,
    input  logic [15:0]           req_y_i,
    input  logic [15:0]           req_len_i,
    input  logic [TW-1:0]         req_tag_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [AW-1:0]         rsp_address_o,
    output logic [$clog2(SW)-1:0] rsp_mb_o,
    output logic [$clog2(SW)-1:0] rsp_me_o,
    output logic                  rsp_first_o,
    output logic                  rsp_last_o,
    output logic                  rsp_clip_o,
    output logic [TW-1:0]         rsp_tag_o
);

    localparam int BN  = $clog2(SW) - 1;
    localparam int KW  = BN - 2;     // offset-in-strip width (PPS <= SW/8)
    localparam int SBL = BN - 2;     // log2 of bytes per strip

    run_state_e    state_q, state_d;

    logic [AW-1:0] base_q;
    logic [1:0]    depth_q;
    logic [15:0]   x_q;
    logic [15:0]   y_q;
    logic [15:0]   cnt_q;            // pixels still to be covered
    logic [TW-1:0] tag_q;
    logic          clip_q;
    logic [AW-1:0] row_q;            // y * num_strips
    logic [15:0]   strip_q;
    logic [KW-1:0] k_q;
    logic          use_div_q;        // first EMIT cycle: strip/k come straight from the divider
    logic          first_q;

    logic          accept;
    logic          hs;
    logic [15:0]   len1;
    logic [16:0]   run_end;
    logic [15:0]   end_px;
    logic [15:0]   cnt_acc;
    logic          clip_acc;

    logic [15:0]   div_x;
    logic [1:0]    div_depth;
    logic [15:0]   div_strip;
    logic [KW-1:0] div_k;
    logic [15:0]   num_strips;

    logic [15:0]   pps;
    logic [BN:0]   bpp_w;
    logic [15:0]   cur_strip;
    logic [KW-1:0] cur_k;
    logic [15:0]   avail;
    logic          cur_last;
    logic [BN:0]   kend;             // exclusive end pixel index inside the strip
    logic [AW-1:0] line_idx;

    assign req_ready_o = (state_q == ST_IDLE);
    assign accept      = req_valid_i & req_ready_o;
    assign hs          = rsp_valid_o & rsp_ready_i;

    // Request decode on the accepting cycle: truncate the run at the bitmap edge.
    always_comb begin
        len1     = (req_len_i == 16'd0) ? 16'd1 : req_len_i;
        run_end  = {1'b0, req_x_i} + {1'b0, len1};
        end_px   = (run_end > {1'b0, bmp_width_i}) ? bmp_width_i : run_end[15:0];
        cnt_acc  = end_px - req_x_i;
        clip_acc = (req_x_i >= bmp_width_i) | (req_y_i >= bmp_height_i);
    end

    // One divider, time-shared: width enters on the accept cycle (result in
    // SETUP2 -> num_strips), x enters in SETUP1 (result in the first EMIT cycle).
    assign div_x     = (state_q == ST_IDLE) ? bmp_width_i   : x_q;
    assign div_depth = (state_q == ST_IDLE) ? color_depth_i : depth_q;

    gfx_strip_div #(.SW(SW)) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .x_i     (div_x),
        .depth_i (div_depth),
        .strip_o (div_strip),
        .k_o     (div_k)
    );

    assign num_strips = div_strip + 16'(div_k != '0);

    // Current response. Only the first strip of a run can start mid-strip;
    // every later strip starts at offset 0.
    always_comb begin
        pps       = pps_f(depth_q, SW);
        bpp_w     = (BN+1)'(bpp_f(depth_q));
        cur_strip = use_div_q ? div_strip : strip_q;
        cur_k     = use_div_q ? div_k     : k_q;
        avail     = pps - 16'(cur_k);
        cur_last  = clip_q | (cnt_q <= avail);
        kend      = cur_last ? (BN+1)'(16'(cur_k) + cnt_q) : (BN+1)'(pps);
        line_idx  = row_q + AW'(cur_strip);
    end

    // Outputs are zero outside EMIT, so reset clears them asynchronously.
    // me wraps correctly when kend*bpp equals SW exactly.
    always_comb begin
        rsp_valid_o   = 1'b0;
        rsp_address_o = '0;
        rsp_mb_o      = '0;
        rsp_me_o      = '0;
        rsp_first_o   = 1'b0;
        rsp_last_o    = 1'b0;
        rsp_clip_o    = 1'b0;
        rsp_tag_o     = '0;
        if (state_q == ST_EMIT) begin
            rsp_valid_o = 1'b1;
            rsp_first_o = first_q;
            rsp_last_o  = cur_last;
            rsp_clip_o  = clip_q;
            rsp_tag_o   = tag_q;
            if (clip_q) begin
                rsp_address_o = base_q;
            end else begin
                rsp_address_o = base_q + (line_idx << SBL);
                rsp_mb_o      = (BN+1)'(cur_k) * bpp_w;
                rsp_me_o      = kend * bpp_w - (BN+1)'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SETUP1;
            ST_SETUP1: state_d = ST_SETUP2;
            ST_SETUP2: state_d = ST_EMIT;
            ST_EMIT:   if (hs && cur_last) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q    <= '0;
            depth_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            tag_q     <= '0;
            clip_q    <= 1'b0;
            row_q     <= '0;
            strip_q   <= '0;
            k_q       <= '0;
            use_div_q <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            if (accept) begin
                base_q  <= base_address_i;
                depth_q <= color_depth_i;
                x_q     <= req_x_i;
                y_q     <= req_y_i;
                cnt_q   <= cnt_acc;
                tag_q   <= req_tag_i;
                clip_q  <= clip_acc;
            end
            if (state_q == ST_SETUP2) begin
                row_q     <= AW'(32'(y_q) * 32'(num_strips));
                use_div_q <= 1'b1;
                first_q   <= 1'b1;
            end
            if (state_q == ST_EMIT) begin
                // Divider output is only valid for one cycle; park it in
                // strip_q/k_q so a stalled first response stays stable.
                use_div_q <= 1'b0;
                if (hs) begin
                    strip_q <= cur_strip + 16'd1;
                    k_q     <= '0;
                    first_q <= 1'b0;
                    cnt_q   <= cnt_q - avail;
                end else begin
                    strip_q <= cur_strip;
                    k_q     <= cur_k;
                end
            end
        end
    end

endmodule

// File: tb/tb_gfx_addr_run_gen.sv
module tb_gfx_addr_run_gen;
    import gfx_pkg::*;

    localparam int SW = 256;
    localparam int AW = 32;
    localparam int TW = 4;
    localparam int BN = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] base_address_i;
    logic [1:0]    color_depth_i;
    logic [15:0]   bmp_width_i;
    logic [15:0]   bmp_height_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [15:0]   req_x_i, req_y_i, req_len_i;
    logic [TW-1:0] req_tag_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [AW-1:0] rsp_address_o;
    logic [BN:0]   rsp_mb_o, rsp_me_o;
    logic          rsp_first_o, rsp_last_o, rsp_clip_o;
    logic [TW-1:0] rsp_tag_o;

    // Config presented on the accept cycle; scrambled afterwards.
    logic [AW-1:0] cfg_base;
    logic [1:0]    cfg_depth;
    logic [15:0]   cfg_w;
    logic [15:0]   cfg_h;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gfx_addr_run_gen #(.SW(SW), .AW(AW), .TW(TW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .base_address_i (base_address_i),
        .color_depth_i  (color_depth_i),
        .bmp_width_i    (bmp_width_i),
        .bmp_height_i   (bmp_height_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_x_i        (req_x_i),
        .req_y_i        (req_y_i),
        .req_len_i      (req_len_i),
        .req_tag_i      (req_tag_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_address_o  (rsp_address_o),
        .rsp_mb_o       (rsp_mb_o),
        .rsp_me_o       (rsp_me_o),
        .rsp_first_o    (rsp_first_o),
        .rsp_last_o     (rsp_last_o),
        .rsp_clip_o     (rsp_clip_o),
        .rsp_tag_o      (rsp_tag_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present one request, then check the 3-cycle response latency.
    task automatic issue(input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] len, input logic [3:0] tg);
        @(negedge clk);
        chk("ready_idle", 64'(req_ready_o), 64'd1);
        base_address_i = cfg_base;
        color_depth_i  = cfg_depth;
        bmp_width_i    = cfg_w;
        bmp_height_i   = cfg_h;
        req_x_i        = x;
        req_y_i        = y;
        req_len_i      = len;
        req_tag_i      = tg;
        req_valid_i    = 1'b1;
        @(negedge clk);
        req_valid_i    = 1'b0;
        req_x_i        = 16'hFFFF;
        req_y_i        = 16'hFFFF;
        req_len_i      = 16'h1234;
        req_tag_i      = ~tg;
        base_address_i = cfg_base ^ 32'hFFFF_0000;
        color_depth_i  = cfg_depth + 2'd1;
        bmp_width_i    = cfg_w ^ 16'h00F0;
        bmp_height_i   = 16'd0;
        chk("ready_busy", 64'(req_ready_o), 64'd0);
        chk("lat1", 64'(rsp_valid_o), 64'd0);
        @(negedge clk);
        chk("lat2", 64'(rsp_valid_o), 64'd0);
        @(negedge clk);
        chk("lat3", 64'(rsp_valid_o), 64'd1);
    endtask

    // Check the presented response, then let it handshake (rsp_ready_i=1).
    task automatic exp_rsp(input string nm, input logic [31:0] a, input int mb, input int me,
                           input bit f, input bit l, input bit c, input int tg);
        int w;
        w = 0;
        while (rsp_valid_o !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({nm, ".vld"},   64'(rsp_valid_o),   64'd1);
        chk({nm, ".addr"},  64'(rsp_address_o), 64'(a));
        chk({nm, ".mb"},    64'(rsp_mb_o),      64'(mb));
        chk({nm, ".me"},    64'(rsp_me_o),      64'(me));
        chk({nm, ".first"}, 64'(rsp_first_o),   64'(f));
        chk({nm, ".last"},  64'(rsp_last_o),    64'(l));
        chk({nm, ".clip"},  64'(rsp_clip_o),    64'(c));
        chk({nm, ".tag"},   64'(rsp_tag_o),     64'(tg));
        @(negedge clk);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".idle_vld"}, 64'(rsp_valid_o), 64'd0);
        chk({nm, ".idle_rdy"}, 64'(req_ready_o), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ea;
        int          me;
        rst_n          = 1'b0;
        req_valid_i    = 1'b0;
        req_x_i        = '0;
        req_y_i        = '0;
        req_len_i      = '0;
        req_tag_i      = '0;
        rsp_ready_i    = 1'b1;
        cfg_base       = 32'h0000_1000;
        cfg_depth      = BPP16;
        cfg_w          = 16'd640;
        cfg_h          = 16'd480;
        base_address_i = cfg_base;
        color_depth_i  = cfg_depth;
        bmp_width_i    = cfg_w;
        bmp_height_i   = cfg_h;

        repeat (2) @(negedge clk);
        chk("rst.rdy",  64'(req_ready_o),   64'd1);
        chk("rst.vld",  64'(rsp_valid_o),   64'd0);
        chk("rst.addr", 64'(rsp_address_o), 64'd0);
        chk("rst.me",   64'(rsp_me_o),      64'd0);
        chk("rst.last", 64'(rsp_last_o),    64'd0);
        rst_n = 1'b1;

        // Single-pixel runs, including length 0 treated as 1.
        cfg_depth = BPP16;
        issue(16'd33, 16'd3, 16'd1, 4'd5);
        exp_rsp("v1", 32'h1F40, 16, 31, 1, 1, 0, 5);
        chk_idle("v1");
        issue(16'd33, 16'd3, 16'd0, 4'd6);
        exp_rsp("v2", 32'h1F40, 16, 31, 1, 1, 0, 6);
        cfg_depth = BPP24;
        issue(16'd25, 16'd0, 16'd1, 4'd7);
        exp_rsp("v3", 32'h1040, 120, 143, 1, 1, 0, 7);

        // Two-strip run.
        cfg_depth = BPP16;
        issue(16'd14, 16'd0, 16'd4, 4'd8);
        exp_rsp("v4a", 32'h1000, 224, 255, 1, 0, 0, 8);
        exp_rsp("v4b", 32'h1020, 0, 31, 0, 1, 0, 8);
        chk_idle("v4");

        // Truncation at the right edge and clips.
        issue(16'd630, 16'd0, 16'd20, 4'd9);
        exp_rsp("v5", 32'h14E0, 96, 255, 1, 1, 0, 9);
        chk_idle("v5");
        issue(16'd640, 16'd0, 16'd1, 4'd10);
        exp_rsp("v6", 32'h1000, 0, 0, 1, 1, 1, 10);
        issue(16'd0, 16'd480, 16'd1, 4'd11);
        exp_rsp("v7", 32'h1000, 0, 0, 1, 1, 1, 11);
        cfg_w = 16'd0;
        issue(16'd0, 16'd0, 16'd1, 4'd12);
        exp_rsp("v8", 32'h1000, 0, 0, 1, 1, 1, 12);
        cfg_w = 16'd640;

        cfg_depth = BPP32;
        issue(16'd9, 16'd1, 16'd10, 4'd13);
        exp_rsp("v9a", 32'h1A20, 32, 255, 1, 0, 0, 13);
        exp_rsp("v9b", 32'h1A40, 0, 95, 0, 1, 0, 13);
        cfg_depth = BPP24;
        issue(16'd8, 16'd1, 16'd5, 4'd14);
        exp_rsp("v10a", 32'h1800, 192, 239, 1, 0, 0, 14);
        exp_rsp("v10b", 32'h1820, 0, 71, 0, 1, 0, 14);

        // Seven-strip run with stalls on the first and fourth responses.
        cfg_depth = BPP8;
        issue(16'd0, 16'd1, 16'd200, 4'd15);
        for (int i = 0; i < 7; i++) begin
            ea = 32'h1000 + 32'((20 + i) * 32);
            me = (i == 6) ? 63 : 255;
            if (i == 0 || i == 3) begin
                rsp_ready_i = 1'b0;
                repeat ((i == 0) ? 2 : 5) begin
                    @(negedge clk);
                    chk("stall.vld",   64'(rsp_valid_o),   64'd1);
                    chk("stall.addr",  64'(rsp_address_o), 64'(ea));
                    chk("stall.me",    64'(rsp_me_o),      64'(me));
                    chk("stall.first", 64'(rsp_first_o),   64'(i == 0));
                end
                rsp_ready_i = 1'b1;
            end
            exp_rsp($sformatf("v11_%0d", i), ea, 0, me, i == 0, i == 6, 0, 15);
        end
        chk_idle("v11");

        // Reset in the middle of a run.
        issue(16'd0, 16'd1, 16'd200, 4'd1);
        exp_rsp("v12a", 32'h1280, 0, 255, 1, 0, 0, 1);
        exp_rsp("v12b", 32'h12A0, 0, 255, 0, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst.vld",   64'(rsp_valid_o),   64'd0);
        chk("mrst.rdy",   64'(req_ready_o),   64'd1);
        chk("mrst.addr",  64'(rsp_address_o), 64'd0);
        chk("mrst.me",    64'(rsp_me_o),      64'd0);
        chk("mrst.first", 64'(rsp_first_o),   64'd0);
        chk("mrst.tag",   64'(rsp_tag_o),     64'd0);
        @(negedge clk);
        chk("mrst.hold", 64'(rsp_valid_o), 64'd0);
        rst_n = 1'b1;
        cfg_depth = BPP16;
        issue(16'd33, 16'd3, 16'd1, 4'd2);
        exp_rsp("v13", 32'h1F40, 16, 31, 1, 1, 0, 2);
        chk_idle("v13");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gfx_addr_run_gen.md
GFX_ADDR_RUN_GEN -- requirements
Module: gfx_addr_run_gen

Interface
REQ-001 SHALL have parameter SW, default 256: strip width in bits; power of two, 32 to 512.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter TW, default 4: request tag width.
REQ-004 SHALL define local BN = $clog2(SW)-1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port base_address_i, input, AW bits: bitmap base byte address.
REQ-008 SHALL have port color_depth_i, input, 2 bits: BPP8/BPP16/BPP24/BPP32 per gfx_pkg.
REQ-009 SHALL have port bmp_width_i, input, 16 bits: bitmap width in pixels.
REQ-010 SHALL have port bmp_height_i, input, 16 bits: bitmap height in lines.
REQ-011 SHALL have ports req_valid_i (input, 1), req_ready_o (output, 1): request handshake.
REQ-012 SHALL have ports req_x_i, req_y_i, req_len_i (input, 16 each): start pixel and run length in pixels; length 0 is treated as 1.
REQ-013 SHALL have port req_tag_i, input, TW bits: opaque request tag.
REQ-014 SHALL have ports rsp_valid_o (output, 1), rsp_ready_i (input, 1): response handshake.
REQ-015 SHALL have port rsp_address_o, output, AW bits: strip byte address.
REQ-016 SHALL have ports rsp_mb_o, rsp_me_o, output, BN+1 bits each: first and last bit in the strip covered by this response.
REQ-017 SHALL have ports rsp_first_o, rsp_last_o, rsp_clip_o, output, 1 bit each: run markers and clip flag.
REQ-018 SHALL have port rsp_tag_o, output, TW bits: echoed request tag.

Function
REQ-019 SHALL use bpp = 8/16/24/32 and PPS = floor(SW/bpp) pixels per strip; unused top bits of a strip are never addressed.
REQ-020 SHALL sample base address, depth, width, height and the request on the accepting cycle (req_valid_i and req_ready_o both high); later config changes SHALL NOT affect the run in progress.
REQ-021 SHALL implement FSM IDLE -> SETUP1 -> SETUP2 -> EMIT -> IDLE.
REQ-022 SHALL assert req_ready_o only in IDLE.
REQ-023 SHALL use SETUP1 and SETUP2 to compute, by exact integer division (no reciprocal approximation): strip = x/PPS; k = x mod PPS; num_strips = ceil(bmp_width/PPS); line index = y*num_strips + strip.
REQ-024 SHALL assert the first rsp_valid_o exactly 3 cycles after acceptance.
REQ-025 SHALL, in EMIT, produce one response per strip touched by pixels x .. min(x+len, bmp_width)-1, in ascending strip order.
REQ-026 SHALL compute each response as: address = base + line_index*(SW/8) (modulo 2^AW); mb = k_first*bpp; me = (k_last+1)*bpp - 1.
REQ-027 SHALL set rsp_first_o on the first response of a run and rsp_last_o on its final response; both SHALL be set on a single-strip run.
REQ-028 SHALL treat x >= bmp_width or y >= bmp_height as a clip: exactly one response with rsp_clip_o=1, first=last=1, address=base, mb=me=0.
REQ-029 SHALL hold all rsp_* outputs stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-030 SHALL sustain one response per cycle while rsp_ready_i=1.
REQ-031 SHALL return to IDLE on the cycle after the last response handshake.
REQ-032 SHALL treat bmp_width_i=0 as a clip.

Reset
REQ-033 SHALL, on rst_n low, immediately force state=IDLE, rsp_valid_o=0, req_ready_o=1 and all other rsp_* outputs to 0, including mid-run; the partial run SHALL be discarded.

Structure
REQ-034 SHALL take the color depth enums (BPP8..BPP32) and the per-depth bpp and PPS functions from gfx_pkg.
REQ-035 SHALL implement the divide/modulo as sub-module gfx_strip_div (x, depth -> strip, k), two-cycle pipelined, reused for num_strips.

Verification
REQ-036 SHALL cover: SW=256, BPP16, width 640, base 0x1000, x=33, y=3, len 1 -> one response at 3 cycles, address 0x1F40, mb=16, me=31, first=last=1.
REQ-037 SHALL cover: BPP24, x=25, y=0, len 1 -> mb=120, me=143, address=base+64.
REQ-038 SHALL cover: BPP16, x=14, len 4 -> 2 responses: (base, 224..255, first) then (base+32, 0..31, last).
REQ-039 SHALL cover: width 640, x=630, len 20, BPP16 -> run truncated to pixels 630..639; x=640 -> single response with clip=1.
REQ-040 SHALL cover: rsp_ready_i held low 5 cycles mid-run -> outputs stable, no response lost or duplicated.
REQ-041 SHALL cover: rst_n pulsed low during EMIT -> rsp_valid_o=0 at once, req_ready_o=1, and the next request is processed normally.
